nanci_pe_seq: RTL and testbench

- Next-generation Nanci mesh processing element with a parametrised data width.
- Adds a writable local program store, a sequencer with a per-instruction repeat count, an accumulator for compare-exchange (min/max) steps, and a start/busy/done control handshake.
- Sits at one node of the SQRT_N x SQRT_N mesh. Takes four neighbour words (left/right/up/down) and drives one registered output word to its neighbours.

---
 rtl/nanci_pe_seq.sv | 172 +++++++++++++++++
 tb/tb_nanci_pe_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nanci_pe_seq.sv
// Nanci mesh processing element with a writable program store, a repeat-count
// sequencer, a min/max accumulator and a start/busy/done handshake.
module nanci_pe_seq #(
    parameter int                    DATA_WIDTH = 6,
    parameter int                    ADDR_WIDTH = 3,
    parameter int                    PROG_DEPTH = 8,
    parameter int                    REP_WIDTH  = 2,
    parameter logic [DATA_WIDTH-1:0] MAX_INT    = {DATA_WIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [ADDR_WIDTH-1:0]  prog_addr,
    input  logic [4+REP_WIDTH:0]   prog_data,
    input  logic [DATA_WIDTH-1:0]  i_PE_l,
    input  logic [DATA_WIDTH-1:0]  i_PE_r,
    input  logic [DATA_WIDTH-1:0]  i_PE_u,
    input  logic [DATA_WIDTH-1:0]  i_PE_d,
    output logic [DATA_WIDTH-1:0]  o_PE,
    output logic [DATA_WIDTH-1:0]  acc,
    output logic                   busy,
    output logic                   done
);

    localparam int INSTR_WIDTH = 5 + REP_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(PROG_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_SEL  = 3'd1,
        OP_LOAD = 3'd2,
        OP_MIN  = 3'd3,
        OP_MAX  = 3'd4,
        OP_EMIT = 3'd5,
        OP_JMP0 = 3'd6,
        OP_HALT = 3'd7
    } op_t;

    logic [INSTR_WIDTH-1:0] mem_r [PROG_DEPTH];

    state_t                 state_r,   state_s;
    logic [ADDR_WIDTH-1:0]  pc_r,      pc_s;
    logic [REP_WIDTH-1:0]   rep_cnt_r, rep_cnt_s;
    logic [DATA_WIDTH-1:0]  o_pe_r,    o_pe_s;
    logic [DATA_WIDTH-1:0]  acc_r,     acc_s;

    logic [INSTR_WIDTH-1:0] instr_s;
    op_t                    op_s;
    logic [1:0]             dir_s;
    logic [REP_WIDTH-1:0]   rep_s;
    logic [DATA_WIDTH-1:0]  nbr_s;
    logic [ADDR_WIDTH-1:0]  pc_inc_s;
    logic                   mem_we_s;

    // Writes are locked out while running and out-of-range addresses are dropped.
    assign mem_we_s = prog_we && (state_r != ST_RUN) && (int'(prog_addr) < PROG_DEPTH);

    assign instr_s  = mem_r[pc_r];
    assign op_s     = op_t'(instr_s[INSTR_WIDTH-1 -: 3]);
    assign dir_s    = instr_s[REP_WIDTH+1 : REP_WIDTH];
    assign rep_s    = instr_s[REP_WIDTH-1:0];
    assign pc_inc_s = (pc_r == LAST_PC) ? {ADDR_WIDTH{1'b0}} : pc_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    assign o_PE = o_pe_r;
    assign acc  = acc_r;
    assign busy = (state_r == ST_RUN);
    assign done = (state_r == ST_DONE);

    // Neighbour selection by the instruction's direction field.
    always_comb begin
        nbr_s = i_PE_l;
        case (dir_s)
            2'd0:    nbr_s = i_PE_l;
            2'd1:    nbr_s = i_PE_r;
            2'd2:    nbr_s = i_PE_u;
            2'd3:    nbr_s = i_PE_d;
            default: nbr_s = i_PE_l;
        endcase
    end

    // Program store: no reset so its contents survive a reset-and-rerun.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    // Sequencer next-state, datapath and repeat-count logic.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        rep_cnt_s = rep_cnt_r;
        o_pe_s    = o_pe_r;
        acc_s     = acc_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s   = ST_RUN;
                    pc_s      = {ADDR_WIDTH{1'b0}};
                    rep_cnt_s = {REP_WIDTH{1'b0}};
                end else begin
                    state_s   = state_r;
                end
            end
            ST_RUN: begin
                // Every op except JMP0/HALT follows the repeat/advance rule.
                if (rep_cnt_r == rep_s) begin
                    pc_s      = pc_inc_s;
                    rep_cnt_s = {REP_WIDTH{1'b0}};
                end else begin
                    rep_cnt_s = rep_cnt_r + {{(REP_WIDTH-1){1'b0}}, 1'b1};
                end
                case (op_s)
                    OP_NOP:  o_pe_s = o_pe_r;
                    OP_SEL:  o_pe_s = nbr_s;
                    OP_LOAD: acc_s  = nbr_s;
                    OP_MIN: begin
                        if (nbr_s < acc_r) begin
                            acc_s = nbr_s;
                        end else begin
                            acc_s = acc_r;
                        end
                    end
                    OP_MAX: begin
                        if (nbr_s > acc_r) begin
                            acc_s = nbr_s;
                        end else begin
                            acc_s = acc_r;
                        end
                    end
                    OP_EMIT: o_pe_s = acc_r;
                    OP_JMP0: begin
                        pc_s      = {ADDR_WIDTH{1'b0}};
                        rep_cnt_s = {REP_WIDTH{1'b0}};
                    end
                    OP_HALT: begin
                        state_s   = ST_DONE;
                        pc_s      = pc_r;
                        rep_cnt_s = rep_cnt_r;
                    end
                    default: state_s = ST_IDLE;
                endcase
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            pc_r      <= {ADDR_WIDTH{1'b0}};
            rep_cnt_r <= {REP_WIDTH{1'b0}};
            o_pe_r    <= {DATA_WIDTH{1'b0}};
            acc_r     <= MAX_INT;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            rep_cnt_r <= rep_cnt_s;
            o_pe_r    <= o_pe_s;
            acc_r     <= acc_s;
        end
    end

endmodule

// File: tb/tb_nanci_pe_seq.sv
// Directed self-checking bench for nanci_pe_seq with hand-computed expectations.
module tb_nanci_pe_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       prog_we;
    logic [2:0] prog_addr;
    logic [6:0] prog_data;
    logic [5:0] i_PE_l, i_PE_r, i_PE_u, i_PE_d;
    logic [5:0] o_PE;
    logic [5:0] acc;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    nanci_pe_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .i_PE_l    (i_PE_l),
        .i_PE_r    (i_PE_r),
        .i_PE_u    (i_PE_u),
        .i_PE_d    (i_PE_d),
        .o_PE      (o_PE),
        .acc       (acc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ins(input logic [2:0] op, input logic [1:0] dir, input logic [1:0] rep);
        return {op, dir, rep};
    endfunction

    task automatic prog(input logic [2:0] addr, input logic [6:0] data);
        prog_addr = addr;
        prog_data = data;
        prog_we   = 1'b1;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = 3'd0; prog_data = 7'd0;
        i_PE_l = 6'd8; i_PE_r = 6'd16; i_PE_u = 6'd24; i_PE_d = 6'd32;
        step();
        check("rst_o_pe", o_PE, 32'd0);
        check("rst_acc",  acc,  32'd63);
        check("rst_busy", busy, 32'd0);
        check("rst_done", done, 32'd0);
        rst = 1'b1;
        step();

        // Select left
        prog(3'd0, ins(3'd1, 2'd0, 2'd0));
        prog(3'd1, ins(3'd7, 2'd0, 2'd0));
        kick();
        check("sel_busy", busy, 32'd1);
        step();
        check("sel_o_pe", o_PE, 32'd8);
        check("sel_done_early", done, 32'd0);
        step();
        check("sel_done", done, 32'd1);
        check("sel_busy_low", busy, 32'd0);
        check("sel_acc_hold", acc, 32'd63);

        // Min over neighbours
        prog(3'd0, ins(3'd2, 2'd2, 2'd0));
        prog(3'd1, ins(3'd3, 2'd0, 2'd0));
        prog(3'd2, ins(3'd3, 2'd3, 2'd0));
        prog(3'd3, ins(3'd3, 2'd1, 2'd0));
        prog(3'd4, ins(3'd5, 2'd0, 2'd0));
        prog(3'd5, ins(3'd7, 2'd0, 2'd0));
        kick();
        step();
        check("min_load_u", acc, 32'd24);
        repeat (5) step();
        check("min_acc",  acc,  32'd8);
        check("min_o_pe", o_PE, 32'd8);
        check("min_done", done, 32'd1);
        i_PE_r = 6'd3;
        kick();
        repeat (6) step();
        check("min_r_o_pe", o_PE, 32'd3);
        check("min_r_acc",  acc,  32'd3);
        i_PE_r = 6'd16;

        // Repeat re-sampling
        prog(3'd0, ins(3'd1, 2'd0, 2'd3));
        prog(3'd1, ins(3'd7, 2'd0, 2'd0));
        kick();
        i_PE_l = 6'd1;
        for (int v = 1; v <= 4; v++) begin
            step();
            check("rep_track", o_PE, 32'(v));
            i_PE_l = 6'(v + 1);
        end
        check("rep_busy4", busy, 32'd1);
        step();
        check("rep_done", done, 32'd1);
        i_PE_l = 6'd8;

        // Write protection, start ignored in RUN, reset mid-run
        prog(3'd0, ins(3'd1, 2'd0, 2'd0));
        prog(3'd1, ins(3'd1, 2'd1, 2'd0));
        prog(3'd2, ins(3'd6, 2'd0, 2'd0));
        kick();
        start = 1'b1;
        prog_addr = 3'd0; prog_data = ins(3'd5, 2'd0, 2'd0); prog_we = 1'b1;
        step();
        check("wp_o1", o_PE, 32'd8);
        step();
        check("wp_o2", o_PE, 32'd16);
        step();
        check("wp_o3", o_PE, 32'd16);
        check("wp_busy", busy, 32'd1);
        prog_we = 1'b0; start = 1'b0;
        step();
        check("wp_prog_kept", o_PE, 32'd8);
        check("wp_busy2", busy, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_o_pe", o_PE, 32'd0);
        check("mid_rst_acc",  acc,  32'd63);
        check("mid_rst_busy", busy, 32'd0);
        check("mid_rst_done", done, 32'd0);
        check("mid_rst_pc",   dut.pc_r, 32'd0);
        rst = 1'b1;
        step();
        kick();
        step();
        check("rerun_o1", o_PE, 32'd8);
        step();
        check("rerun_o2", o_PE, 32'd16);
        rst = 1'b0; #1; rst = 1'b1;
        step();

        // PC wrap
        for (int a = 0; a < 7; a++) prog(3'(a), ins(3'd0, 2'd0, 2'd0));
        prog(3'd7, ins(3'd1, 2'd3, 2'd0));
        kick();
        repeat (7) step();
        check("wrap_o_pe_pre", o_PE, 32'd0);
        step();
        check("wrap_o_pe", o_PE, 32'd32);
        check("wrap_pc",   dut.pc_r, 32'd0);
        check("wrap_busy", busy, 32'd1);
        step();
        check("wrap_busy2", busy, 32'd1);
        rst = 1'b0; #1; rst = 1'b1;
        step();

        // Program write and start in the same IDLE cycle
        prog_addr = 3'd0; prog_data = ins(3'd1, 2'd2, 2'd0); prog_we = 1'b1; start = 1'b1;
        step();
        prog_we = 1'b0; start = 1'b0;
        step();
        check("we_start_o_pe", o_PE, 32'd24);
        rst = 1'b0; #1; rst = 1'b1;
        step();

        // Restart from DONE keeps the accumulator
        prog(3'd0, ins(3'd2, 2'd0, 2'd0));
        prog(3'd1, ins(3'd7, 2'd0, 2'd0));
        kick();
        step(); step();
        check("rs_first_done", done, 32'd1);
        check("rs_first_acc",  acc,  32'd8);
        prog(3'd0, ins(3'd4, 2'd3, 2'd0));
        prog(3'd1, ins(3'd5, 2'd0, 2'd0));
        prog(3'd2, ins(3'd7, 2'd0, 2'd0));
        kick();
        check("rs_pc0", dut.pc_r, 32'd0);
        check("rs_busy", busy, 32'd1);
        step();
        check("rs_max_acc", acc, 32'd32);
        step();
        check("rs_emit", o_PE, 32'd32);
        step();
        check("rs_done", done, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
